// File: rtl/multiboot_pkg.sv
// Shared ICAP constants, FSM encodings and byte bit-reversal
// for the Spartan-6 multiboot sequencer.
package multiboot_pkg;

  localparam logic [15:0] SYNC1      = 16'hAA99;
  localparam logic [15:0] SYNC2      = 16'h5566;
  localparam logic [15:0] CMD_HDR    = 16'h30A1;
  localparam logic [15:0] CMD_NULL   = 16'h0000;
  localparam logic [15:0] GEN1_HDR   = 16'h3261;
  localparam logic [15:0] GEN2_HDR   = 16'h3281;
  localparam logic [15:0] GEN3_HDR   = 16'h32A1;
  localparam logic [15:0] GEN4_HDR   = 16'h32C1;
  localparam logic [15:0] MODE_HDR   = 16'h3301;
  localparam logic [15:0] MODE_QUAD  = 16'h3100;
  localparam logic [15:0] CMD_REBOOT = 16'h000E;
  localparam logic [15:0] NOOP       = 16'h2000;
  localparam logic [15:0] IDLE_WORD  = 16'hFFFF;

  localparam logic [7:0] OP_QUAD = 8'h6B;
  localparam logic [7:0] OP_SPI  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FIN
  } state_t;

  // ICAP wants bit 0 of each byte on its MSB pin
  function automatic logic [15:0] byte_rev16(
    input logic [15:0] w
  );
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[7-b]  = w[b];
      r[15-b] = w[8+b];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_multiboot_ctrl_btn_debounce.sv
// Boot button synchroniser and debouncer; level idles high
// and release_pulse marks the debounced 0->1 transition.
module btn_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic in_n,
  output logic level,
  output logic release_pulse
);

  logic [1:0]          sync_q;
  logic [DEB_BITS-1:0] cnt_q;
  logic                level_q;
  logic                rel_q;
  logic                differ;
  logic                flip;

  assign differ = sync_q[1] != level_q;
  assign flip   = differ && (&cnt_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rel_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], in_n};
      rel_q  <= flip && !level_q;
      if (flip) begin
        level_q <= ~level_q;
      end
      // any agreeing sample restarts the stability window
      if (!differ || flip) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level         = level_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// Spartan-6 ICAP warm-reboot sequencer: streams the IPROG
// word list for a selected flash slot, one word per clock.
module icap_multiboot_ctrl
  import multiboot_pkg::*;
#(
  parameter int          SLOTS     = 4,
  parameter logic [23:0] BASE_ADDR = 24'h0,
  parameter logic [23:0] SLOT_SIZE = 24'h100000,
  parameter logic [23:0] FALLBACK  = 24'h0,
  parameter bit          QUAD      = 1'b1,
  parameter int          BTN_SLOT  = 0,
  parameter int          DEB_BITS  = 16,
  localparam int         SW        = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [SW-1:0] slot,
  input  logic          boot_n,
  input  logic          icap_busy,
  output logic          busy,
  output logic          err,
  output logic          done,
  output logic          icap_ce_n,
  output logic          icap_wr_n,
  output logic [15:0]   icap_i
);

  localparam int         N    = QUAD ? 20 : 18;
  localparam logic [4:0] LAST = 5'(N - 1);
  localparam logic [7:0] OP   = QUAD ? OP_QUAD : OP_SPI;

  function automatic logic [15:0] word_at(
    input logic [4:0]  idx,
    input logic [23:0] a
  );
    logic [4:0]  k;
    logic [15:0] w;
    // serial read skips the two MODE words
    k = (!QUAD && idx >= 5'd12) ? idx + 5'd2 : idx;
    unique case (k)
      5'd0:    w = SYNC1;
      5'd1:    w = SYNC2;
      5'd2:    w = CMD_HDR;
      5'd3:    w = CMD_NULL;
      5'd4:    w = GEN1_HDR;
      5'd5:    w = a[15:0];
      5'd6:    w = GEN2_HDR;
      5'd7:    w = {OP, a[23:16]};
      5'd8:    w = GEN3_HDR;
      5'd9:    w = FALLBACK[15:0];
      5'd10:   w = GEN4_HDR;
      5'd11:   w = {OP, FALLBACK[23:16]};
      5'd12:   w = MODE_HDR;
      5'd13:   w = MODE_QUAD;
      5'd14:   w = CMD_HDR;
      5'd15:   w = CMD_REBOOT;
      default: w = NOOP;
    endcase
    return w;
  endfunction

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [23:0]   addr_q, addr_d;
  logic          ce_q, ce_d;
  logic [15:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          btn_level;
  logic          btn_rel;
  logic          slot_ok;
  logic          start;
  logic          bad;
  logic [SW-1:0] start_slot;
  logic [23:0]   addr_req;

  btn_debounce #(
    .DEB_BITS(DEB_BITS)
  ) u_btn (
    .clock         (clock),
    .reset         (reset),
    .in_n          (boot_n),
    .level         (btn_level),
    .release_pulse (btn_rel)
  );

  assign slot_ok  = 32'(slot) < SLOTS;
  assign addr_req = BASE_ADDR + SLOT_SIZE * 24'(start_slot);

  always_comb begin
    start      = 1'b0;
    bad        = 1'b0;
    start_slot = slot;
    if (state_q == ST_IDLE) begin
      unique case (1'b1)
        req: begin
          start = slot_ok;
          bad   = !slot_ok;
        end
        (btn_rel && btn_level): begin
          start      = 1'b1;
          start_slot = SW'(BTN_SLOT);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    ce_d    = ce_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = bad;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          idx_d   = '0;
          addr_d  = addr_req;
          ce_d    = 1'b0;
          data_d  = byte_rev16(word_at(5'd0, addr_req));
        end
      end
      ST_SEND: begin
        if (!icap_busy) begin
          if (idx_q == LAST) begin
            state_d = ST_FIN;
            ce_d    = 1'b1;
            data_d  = IDLE_WORD;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 5'd1;
            data_d = byte_rev16(word_at(idx_d, addr_q));
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ce_d    = 1'b1;
        data_d  = IDLE_WORD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      ce_q    <= 1'b1;
      data_q  <= IDLE_WORD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ce_q    <= ce_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = state_q == ST_SEND;
  assign err       = err_q;
  assign done      = done_q;
  assign icap_ce_n = ce_q;
  assign icap_wr_n = ce_q;
  assign icap_i    = data_q;

endmodule
